// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and helpers for the PS/2 keyboard character path.
//   - Scancode set 2 constants (prefixes and modifier/control keys)
//   - ASCII control constants pushed for special keys
//   - Decoder FSM state enum
//   - scancode_to_ascii lookup (plain and shifted character per scancode)
//   - ext_to_ascii lookup for E0-prefixed navigation keys
package ps2_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_NUM    = 8'h77;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_TAB    = 8'h0D;
  localparam logic [7:0] SC_ESC    = 8'h76;

  localparam logic [7:0] ASC_LF    = 8'h0A;
  localparam logic [7:0] ASC_BS    = 8'h08;
  localparam logic [7:0] ASC_TAB   = 8'h09;
  localparam logic [7:0] ASC_ESC   = 8'h1B;
  localparam logic [7:0] ASC_UP    = 8'h11;
  localparam logic [7:0] ASC_DOWN  = 8'h12;
  localparam logic [7:0] ASC_LEFT  = 8'h13;
  localparam logic [7:0] ASC_RIGHT = 8'h14;
  localparam logic [7:0] ASC_DEL   = 8'h7F;

  typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} kbd_state_e;

  // Returns {plain, shifted}; 16'h0 for keys that produce no character.
  function automatic logic [15:0] sc_pair(input logic [7:0] code);
    logic [15:0] p;
    p = 16'h0000;
    case (code)
      8'h1C: p = "aA";  8'h32: p = "bB";  8'h21: p = "cC";  8'h23: p = "dD";
      8'h24: p = "eE";  8'h2B: p = "fF";  8'h34: p = "gG";  8'h33: p = "hH";
      8'h43: p = "iI";  8'h3B: p = "jJ";  8'h42: p = "kK";  8'h4B: p = "lL";
      8'h3A: p = "mM";  8'h31: p = "nN";  8'h44: p = "oO";  8'h4D: p = "pP";
      8'h15: p = "qQ";  8'h2D: p = "rR";  8'h1B: p = "sS";  8'h2C: p = "tT";
      8'h3C: p = "uU";  8'h2A: p = "vV";  8'h1D: p = "wW";  8'h22: p = "xX";
      8'h35: p = "yY";  8'h1A: p = "zZ";
      8'h45: p = "0)";  8'h16: p = "1!";  8'h1E: p = "2@";  8'h26: p = "3#";
      8'h25: p = "4$";  8'h2E: p = "5%";  8'h36: p = "6^";  8'h3D: p = "7&";
      8'h3E: p = "8*";  8'h46: p = "9(";
      8'h0E: p = "`~";  8'h4E: p = "-_";  8'h55: p = "=+";  8'h5D: p = "\\|";
      8'h54: p = "[{";  8'h5B: p = "]}";  8'h4C: p = ";:";  8'h52: p = "'\"";
      8'h41: p = ",<";  8'h49: p = ".>";  8'h4A: p = "/?";  8'h29: p = "  ";
      // Keypad keys ignore shift.
      8'h70: p = "00";  8'h69: p = "11";  8'h72: p = "22";  8'h7A: p = "33";
      8'h6B: p = "44";  8'h73: p = "55";  8'h74: p = "66";  8'h6C: p = "77";
      8'h75: p = "88";  8'h7D: p = "99";  8'h71: p = "..";  8'h79: p = "++";
      8'h7B: p = "--";  8'h7C: p = "**";
      SC_ENTER: p = {ASC_LF, ASC_LF};
      SC_BKSP:  p = {ASC_BS, ASC_BS};
      SC_TAB:   p = {ASC_TAB, ASC_TAB};
      SC_ESC:   p = {ASC_ESC, ASC_ESC};
      default:  p = 16'h0000;
    endcase
    return p;
  endfunction

  // Letters are the only keys where caps lock participates in the case choice.
  function automatic logic sc_is_letter(input logic [7:0] code);
    logic [15:0] p;
    p = sc_pair(code);
    return (p[15:8] >= 8'h61) && (p[15:8] <= 8'h7A);
  endfunction

  function automatic logic [7:0] scancode_to_ascii(input logic [7:0] code, input logic upper);
    logic [15:0] p;
    p = sc_pair(code);
    return upper ? p[7:0] : p[15:8];
  endfunction

  function automatic logic [7:0] ext_to_ascii(input logic [7:0] code);
    logic [7:0] c;
    case (code)
      8'h75:    c = ASC_UP;
      8'h72:    c = ASC_DOWN;
      8'h6B:    c = ASC_LEFT;
      8'h74:    c = ASC_RIGHT;
      8'h71:    c = ASC_DEL;
      SC_ENTER: c = ASC_LF;
      default:  c = 8'h00;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/char_fifo.sv
// char_fifo: first-word-fall-through byte FIFO with occupancy count.
// Ports:
//   clk, clrn       clock, synchronous active-low reset
//   wr_en, wr_data  write request; accepted when not full, or when full and a pop happens
//   rd_en           pop the head entry; ignored while empty
//   rd_data         head entry, valid while !empty
//   empty, full     occupancy flags
//   count           occupancy 0..DEPTH
module char_fifo #(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  assign do_rd = rd_en && !empty;
  // A simultaneous pop frees the slot the write lands in, so full does not block it.
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + (AW + 1)'(do_wr) - (AW + 1)'(do_rd);
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; contents are only observable once written.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/ps2_char_fifo.sv
// ps2_char_fifo: drains scancode bytes from ps2_keyboard, decodes make/break/
// extended sequences, tracks shift and caps lock, and queues ASCII characters
// in a DEPTH-entry FWFT FIFO read by the CPU.
// Optional feature macro: KEY_EXT_NAV_EN (E0-prefixed arrows, delete and
// keypad enter produce control characters; otherwise extended makes are dropped).
// Ports:
//   clk_50m, clrn        clock, synchronous active-low reset
//   ps2_data, ps2_ready  byte offered by ps2_keyboard
//   ps2_nextdata_n       low for one cycle when a byte has been taken
//   rd_en, rd_data       CPU pop / head character (valid while !empty)
//   empty, full, count   FIFO status
//   ovf, ovf_clr         sticky dropped-character flag and its clear
//   keydbgdata           {caps,shift,2'b0,count[3:0],key_count,ascii,last_code}
// Handshake: a byte is taken on an edge where ps2_ready=1 and ps2_nextdata_n=1;
// ps2_nextdata_n then reads 0 for exactly one cycle, so at most one byte per
// two cycles. The decoded character is pushed on the following edge.
module ps2_char_fifo #(
  parameter int  DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_50m,
  input  logic          clrn,
  input  logic [7:0]    ps2_data,
  input  logic          ps2_ready,
  output logic          ps2_nextdata_n,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic [31:0]   keydbgdata
);
  import ps2_pkg::*;

  logic       nextdata_n_q, byte_vld_q;
  logic [7:0] byte_q;
  kbd_state_e state_q, state_d;
  logic       shift_l_q, shift_l_d, shift_r_q, shift_r_d, caps_q, caps_d;
  logic [7:0] key_count_q, key_count_d, ascii_q, ascii_d;
  logic       ovf_q, ovf_d;
  logic       push, fifo_wr, upper;
  logic [7:0] push_data;
  logic [3:0] cnt4;

  always_ff @(posedge clk_50m) begin
    if (!clrn) begin
      nextdata_n_q <= 1'b1;
      byte_vld_q   <= 1'b0;
      byte_q       <= 8'h00;
    end else if (ps2_ready && nextdata_n_q) begin
      nextdata_n_q <= 1'b0;
      byte_vld_q   <= 1'b1;
      byte_q       <= ps2_data;
    end else begin
      nextdata_n_q <= 1'b1;
      byte_vld_q   <= 1'b0;
    end
  end

  assign ps2_nextdata_n = nextdata_n_q;

  // Caps lock flips case only for letters; digits/punctuation follow shift alone.
  assign upper = sc_is_letter(byte_q) ? ((shift_l_q | shift_r_q) ^ caps_q)
                                      : (shift_l_q | shift_r_q);

  always_comb begin
    state_d     = state_q;
    shift_l_d   = shift_l_q;
    shift_r_d   = shift_r_q;
    caps_d      = caps_q;
    key_count_d = key_count_q;
    push        = 1'b0;
    push_data   = 8'h00;
    if (byte_vld_q) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_q == SC_BREAK) begin
            state_d = ST_BRK;
          end else if (byte_q == SC_EXT) begin
            state_d = ST_EXT;
          end else begin
            key_count_d = key_count_q + 8'd1;
            case (byte_q)
              SC_LSHIFT: shift_l_d = 1'b1;
              SC_RSHIFT: shift_r_d = 1'b1;
              SC_CAPS:   caps_d    = ~caps_q;
              SC_CTRL, SC_ALT, SC_NUM: ;
              default: begin
                push_data = scancode_to_ascii(byte_q, upper);
                push      = (push_data != 8'h00);
              end
            endcase
          end
        end
        ST_BRK: begin
          if (byte_q == SC_LSHIFT) shift_l_d = 1'b0;
          if (byte_q == SC_RSHIFT) shift_r_d = 1'b0;
          state_d = ST_IDLE;
        end
        ST_EXT: begin
          if (byte_q == SC_BREAK) begin
            state_d = ST_EXT_BRK;
          end else begin
            key_count_d = key_count_q + 8'd1;
            state_d     = ST_IDLE;
`ifdef KEY_EXT_NAV_EN
            push_data = ext_to_ascii(byte_q);
            push      = (push_data != 8'h00);
`endif
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign fifo_wr = push && (!full || rd_en);
  assign ascii_d = push ? push_data : ascii_q;

  // A drop in the same cycle as ovf_clr wins so no overflow is ever lost.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (push && full && !rd_en) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_50m) begin
    if (!clrn) begin
      state_q     <= ST_IDLE;
      shift_l_q   <= 1'b0;
      shift_r_q   <= 1'b0;
      caps_q      <= 1'b0;
      key_count_q <= 8'h00;
      ascii_q     <= 8'h00;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_l_q   <= shift_l_d;
      shift_r_q   <= shift_r_d;
      caps_q      <= caps_d;
      key_count_q <= key_count_d;
      ascii_q     <= ascii_d;
      ovf_q       <= ovf_d;
    end
  end

  char_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk_50m),
    .clrn    (clrn),
    .wr_en   (fifo_wr),
    .wr_data (push_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

  assign ovf        = ovf_q;
  assign cnt4       = 4'(count);
  assign keydbgdata = {caps_q, shift_l_q | shift_r_q, 2'b00, cnt4, key_count_q, ascii_q, byte_q};

endmodule

// File: tb/tb_ps2_char_fifo.sv
// tb_ps2_char_fifo: directed scancode sequences with hand-computed characters.
// Expected characters go into exp_q as stimulus is issued; a monitor pops and
// compares whenever the bench reads a non-empty FIFO.
module tb_ps2_char_fifo;
  import ps2_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk_50m = 1'b0;
  logic          clrn = 1'b0;
  logic [7:0]    ps2_data = 8'h00;
  logic          ps2_ready = 1'b0;
  logic          ps2_nextdata_n;
  logic          rd_en = 1'b0;
  logic [7:0]    rd_data;
  logic          empty, full, ovf;
  logic [AW:0]   count;
  logic          ovf_clr = 1'b0;
  logic [31:0]   keydbgdata;

  logic [7:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int pulses = 0;

  ps2_char_fifo #(.DEPTH(DEPTH)) dut (
    .clk_50m(clk_50m), .clrn(clrn), .ps2_data(ps2_data), .ps2_ready(ps2_ready),
    .ps2_nextdata_n(ps2_nextdata_n), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .count(count), .ovf(ovf), .ovf_clr(ovf_clr),
    .keydbgdata(keydbgdata)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_50m = ~clk_50m;

  task automatic do_reset();
    @(posedge clk_50m); #1;
    clrn = 1'b0;
    repeat (2) @(posedge clk_50m);
    #1 clrn = 1'b1;
    pulses = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [7:0] c);
    exp_q.push_back(c);
  endtask

  // Monitor: every accepted pop is compared against the scoreboard head.
  always @(negedge clk_50m) begin
    if (clrn && rd_en && !empty) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_data: got %0h expected no entry", rd_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_err++;
          $display("FAIL rd_data: got %0h expected %0h", rd_data, e);
        end
      end
    end
  end

  always @(negedge clk_50m) begin
    if (!ps2_nextdata_n) pulses++;
  end

  // ---------------- drivers ----------------
  // Offers one byte like ps2_keyboard. 'pop' and 'clr' are asserted for the
  // cycle in which the decoded character is pushed.
  task automatic send_byte(input logic [7:0] b, input bit pop = 1'b0, input bit clr = 1'b0);
    bit taken;
    taken = 1'b0;
    ps2_data  = b;
    ps2_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_50m); #1;
      if (!ps2_nextdata_n) begin
        taken = 1'b1;
        break;
      end
    end
    ps2_ready = 1'b0;
    if (!taken) check("byte_taken", 32'(taken), 32'd1);
    rd_en   = pop;
    ovf_clr = clr;
    @(posedge clk_50m); #1;
    rd_en   = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (!empty && n < 40) begin
      rd_en = 1'b1;
      @(posedge clk_50m); #1;
      n++;
    end
    rd_en = 1'b0;
    check("drain_empty", 32'(empty), 32'd1);
    check("scoreboard_left", exp_q.size(), 32'd0);
  endtask

  task automatic pulse_ovf_clr();
    ovf_clr = 1'b1;
    @(posedge clk_50m); #1;
    ovf_clr = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    @(negedge clk_50m);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    check("rst_nextdata_n", 32'(ps2_nextdata_n), 32'd1);
    check("rst_dbg", keydbgdata, 32'h0000_0000);

    // 1: press/release 'a'
    @(posedge clk_50m); #1;
    exp_push(8'h61);
    send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    check("t1_count", 32'(count), 32'd1);
    check("t1_pulses", pulses, 32'd3);
    check("t1_fsm_idle", 32'(dut.state_q), 32'(ST_IDLE));
    check("t1_dbg", keydbgdata, 32'h0101_611C);
    drain();

    // 2: shifted then unshifted 'a'
    do_reset();
    exp_push(8'h41); exp_push(8'h61);
    send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h1C);
    send_byte(8'hF0); send_byte(8'h12); send_byte(8'h1C);
    check("t2_shift_clear", 32'(keydbgdata[30]), 32'd0);
    check("t2_count", 32'(count), 32'd2);
    drain();

    // 3: caps lock interplay with shift on letters and digits
    do_reset();
    exp_push(8'h41);
    send_byte(8'h58); send_byte(8'hF0); send_byte(8'h58); send_byte(8'h1C);
    check("t3_caps", 32'(keydbgdata[31]), 32'd1);
    exp_push(8'h61); exp_push(8'h21);
    send_byte(8'h12); send_byte(8'h1C); send_byte(8'h16);
    exp_push(8'h31);
    send_byte(8'hF0); send_byte(8'h12); send_byte(8'h16);
    exp_push(8'h0A);
    send_byte(8'h5A);
    drain();
    rd_en = 1'b1;                       // pop on empty is ignored
    @(posedge clk_50m); #1;
    rd_en = 1'b0;
    check("t3_rd_empty_count", 32'(count), 32'd0);

    // 4: overflow with repeated makes
    do_reset();
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i < DEPTH) exp_push(8'h61);
      send_byte(8'h1C);
    end
    check("t4_full", 32'(full), 32'd1);
    check("t4_count", 32'(count), 32'(DEPTH));
    check("t4_ovf", 32'(ovf), 32'd1);
    pulse_ovf_clr();
    check("t4_ovf_clr", 32'(ovf), 32'd0);

    // 5: push and pop together while full
    exp_push(8'h62);
    send_byte(8'h32, 1'b1, 1'b0);
    check("t5_count", 32'(count), 32'(DEPTH));
    check("t5_ovf", 32'(ovf), 32'd0);
    check("t5_full", 32'(full), 32'd1);

    // drop coinciding with ovf_clr keeps ovf set
    send_byte(8'h1C, 1'b0, 1'b1);
    check("t5_ovf_sticky", 32'(ovf), 32'd1);
    check("t5_count2", 32'(count), 32'(DEPTH));
    pulse_ovf_clr();
    drain();

    // 6: extended up arrow
    do_reset();
`ifdef KEY_EXT_NAV_EN
    exp_push(8'h11);
`endif
    send_byte(8'hE0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
`ifdef KEY_EXT_NAV_EN
    check("t6_count_nav", 32'(count), 32'd1);
`else
    check("t6_empty", 32'(empty), 32'd1);
`endif
    check("t6_fsm_idle", 32'(dut.state_q), 32'(ST_IDLE));
    drain();

    // reset between E0 and 75 discards the prefix: keypad '8'
    send_byte(8'hE0);
    do_reset();
    exp_push(8'h38);
    send_byte(8'h75);
    check("t6_reset_count", 32'(count), 32'd1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
